// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator call scheduler: FSM states and hall-call
// direction values.
package elevator_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_UP    = 2'd1,
    S_DOWN  = 2'd2,
    S_SERVE = 2'd3
  } sched_state_t;

  localparam logic HALL_UP = 1'b1;
  localparam logic HALL_DN = 1'b0;

endpackage

// File: rtl/floor_seek.sv
// Combinational floor search: lowest set bit above, or highest set bit below,
// a given floor. With bounded=0 the whole vector is searched.
module floor_seek #(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FLOOR_W  = 3
) (
  input  logic [N_FLOORS-1:0] vec,
  input  logic [FLOOR_W-1:0]  floor,
  input  logic                seek_up,
  input  logic                bounded,
  output logic                found,
  output logic [FLOOR_W-1:0]  idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      if (seek_up) begin
        // First hit on an ascending scan is the lowest floor.
        if (vec[i] && !found && (!bounded || i > 32'(floor))) begin
          found = 1'b1;
          idx   = FLOOR_W'(i);
        end
      end else begin
        if (vec[i] && (!bounded || i < 32'(floor))) begin
          found = 1'b1;
          idx   = FLOOR_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Hall/cab call registry with SCAN target selection for N_FLOORS floors.
// Feeds a registered target floor and sweep direction to the motor/door FSM.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned FLOOR_W  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                call_valid,
  input  logic [FLOOR_W-1:0]  call_floor,
  input  logic                call_up,
  input  logic                call_cab,
  input  logic [FLOOR_W-1:0]  actual_floor,
  input  logic                car_stopped,
  input  logic                served,
  output logic [FLOOR_W-1:0]  target_floor,
  output logic                target_valid,
  output logic                dir_up,
  output logic [1:0]          sched_state,
  output logic [N_FLOORS-1:0] pending,
  output logic                call_reject
);

  sched_state_t state, state_nxt;

  logic [N_FLOORS-1:0] up_req, dn_req, cab_req;
  logic [N_FLOORS-1:0] up_nxt, dn_nxt, cab_nxt;
  logic [N_FLOORS-1:0] set_vec, here_vec, above_mask, below_mask;
  logic [N_FLOORS-1:0] clr_up, clr_dn, clr_cab;
  logic [N_FLOORS-1:0] seek_up_vec, seek_dn_vec;
  logic                floor_ok, call_ok, reject_nxt;
  logic                set_up, set_dn, set_cab;
  logic                any_above, any_below, beyond, pend_here;
  logic [FLOOR_W-1:0]  tgt_nxt;
  logic                tv_nxt, dir_nxt;

  logic                p_up_found, s_up_found, p_dn_found, s_dn_found;
  logic [FLOOR_W-1:0]  p_up_idx, s_up_idx, p_dn_idx, s_dn_idx;
  logic                up_found, dn_found;
  logic [FLOOR_W-1:0]  up_idx, dn_idx;

  assign pending     = up_req | dn_req | cab_req;
  assign sched_state = state;
  assign floor_ok    = 32'(actual_floor) < N_FLOORS;

  always_comb begin
    above_mask = '0;
    below_mask = '0;
    set_vec    = '0;
    here_vec   = '0;
    pend_here  = 1'b0;
    for (int unsigned i = 0; i < N_FLOORS; i++) begin
      above_mask[i] = i > 32'(actual_floor);
      below_mask[i] = i < 32'(actual_floor);
      set_vec[i]    = 32'(call_floor) == i;
      here_vec[i]   = 32'(actual_floor) == i;
      if (32'(actual_floor) == i) pend_here = pending[i];
    end
    any_above = |(pending & above_mask);
    any_below = |(pending & below_mask);
    beyond    = dir_up ? any_above : any_below;

    call_ok = call_valid && (32'(call_floor) < N_FLOORS);
    if (!call_cab && call_up == HALL_UP && 32'(call_floor) == N_FLOORS - 1) call_ok = 1'b0;
    if (!call_cab && call_up == HALL_DN && call_floor == '0) call_ok = 1'b0;
    reject_nxt = call_valid && !call_ok;
    set_cab    = call_ok && call_cab;
    set_up     = call_ok && !call_cab && call_up == HALL_UP;
    set_dn     = call_ok && !call_cab && call_up == HALL_DN;

    clr_up  = '0;
    clr_dn  = '0;
    clr_cab = '0;
    if (state == S_SERVE && served && floor_ok) begin
      clr_cab = here_vec;
      if (dir_up) begin
        clr_up = here_vec;
        if (!beyond) clr_dn = here_vec;
      end else begin
        clr_dn = here_vec;
        if (!beyond) clr_up = here_vec;
      end
    end

    up_nxt  = (up_req  | (set_vec & {N_FLOORS{set_up}}))  & ~clr_up;
    dn_nxt  = (dn_req  | (set_vec & {N_FLOORS{set_dn}}))  & ~clr_dn;
    cab_nxt = (cab_req | (set_vec & {N_FLOORS{set_cab}})) & ~clr_cab;
  end

  // In IDLE the near searches look at every pending floor to find the nearest call.
  assign seek_up_vec = (state == S_IDLE) ? pending : (up_req | cab_req);
  assign seek_dn_vec = (state == S_IDLE) ? pending : (dn_req | cab_req);

  floor_seek #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_seek_up_near (
    .vec(seek_up_vec), .floor(actual_floor), .seek_up(1'b1), .bounded(1'b1),
    .found(p_up_found), .idx(p_up_idx)
  );
  floor_seek #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_seek_up_far (
    .vec(dn_req), .floor(actual_floor), .seek_up(1'b0), .bounded(1'b0),
    .found(s_up_found), .idx(s_up_idx)
  );
  floor_seek #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_seek_dn_near (
    .vec(seek_dn_vec), .floor(actual_floor), .seek_up(1'b0), .bounded(1'b1),
    .found(p_dn_found), .idx(p_dn_idx)
  );
  floor_seek #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_seek_dn_far (
    .vec(up_req), .floor(actual_floor), .seek_up(1'b1), .bounded(1'b0),
    .found(s_dn_found), .idx(s_dn_idx)
  );

  // Far searches span the whole vector; only hits beyond the car count.
  assign up_found = p_up_found || (s_up_found && s_up_idx > actual_floor);
  assign up_idx   = p_up_found ? p_up_idx : s_up_idx;
  assign dn_found = p_dn_found || (s_dn_found && s_dn_idx < actual_floor);
  assign dn_idx   = p_dn_found ? p_dn_idx : s_dn_idx;

  always_comb begin
    state_nxt = state;
    tgt_nxt   = target_floor;
    tv_nxt    = target_valid;
    dir_nxt   = dir_up;
    if (!floor_ok) begin
      state_nxt = S_IDLE;
      tv_nxt    = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pending == '0) begin
            tv_nxt = 1'b0;
          end else if (pend_here && car_stopped) begin
            state_nxt = S_SERVE;
            tgt_nxt   = actual_floor;
            tv_nxt    = 1'b1;
          end else if (p_up_found &&
                       (!p_dn_found || (p_up_idx - actual_floor) <= (actual_floor - p_dn_idx))) begin
            state_nxt = S_UP;
            dir_nxt   = 1'b1;
            tgt_nxt   = p_up_idx;
            tv_nxt    = 1'b1;
          end else if (p_dn_found) begin
            state_nxt = S_DOWN;
            dir_nxt   = 1'b0;
            tgt_nxt   = p_dn_idx;
            tv_nxt    = 1'b1;
          end else begin
            tv_nxt = 1'b0;
          end
        end
        S_UP: begin
          // Strict-above searches lose the target once the car reaches it, so hold it.
          if (target_valid && actual_floor == target_floor && pend_here) begin
            if (car_stopped) state_nxt = S_SERVE;
          end else if (up_found) begin
            tgt_nxt = up_idx;
            tv_nxt  = 1'b1;
          end else if (dn_found) begin
            state_nxt = S_DOWN;
            dir_nxt   = 1'b0;
            tgt_nxt   = dn_idx;
            tv_nxt    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            tv_nxt    = 1'b0;
          end
        end
        S_DOWN: begin
          if (target_valid && actual_floor == target_floor && pend_here) begin
            if (car_stopped) state_nxt = S_SERVE;
          end else if (dn_found) begin
            tgt_nxt = dn_idx;
            tv_nxt  = 1'b1;
          end else if (up_found) begin
            state_nxt = S_UP;
            dir_nxt   = 1'b1;
            tgt_nxt   = up_idx;
            tv_nxt    = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            tv_nxt    = 1'b0;
          end
        end
        S_SERVE: begin
          if (served) begin
            if (dir_up ? up_found : !dn_found && up_found) begin
              state_nxt = S_UP;
              dir_nxt   = 1'b1;
              tgt_nxt   = up_idx;
            end else if (dn_found) begin
              state_nxt = S_DOWN;
              dir_nxt   = 1'b0;
              tgt_nxt   = dn_idx;
            end else begin
              state_nxt = S_IDLE;
              tv_nxt    = 1'b0;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      up_req       <= '0;
      dn_req       <= '0;
      cab_req      <= '0;
      state        <= S_IDLE;
      target_floor <= '0;
      target_valid <= 1'b0;
      dir_up       <= 1'b1;
      call_reject  <= 1'b0;
    end else begin
      up_req       <= up_nxt;
      dn_req       <= dn_nxt;
      cab_req      <= cab_nxt;
      state        <= state_nxt;
      target_floor <= tgt_nxt;
      target_valid <= tv_nxt;
      dir_up       <= dir_nxt;
      call_reject  <= reject_nxt;
    end
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Scoreboard bench for elevator_call_scheduler: every change of the observable
// output tuple is popped against a queue of hand-computed expected tuples.
module tb_elevator_call_scheduler;

  localparam int unsigned NF = 8;
  localparam int unsigned FW = 4;

  typedef struct packed {
    logic [1:0]    st;
    logic          tv;
    logic [FW-1:0] tgt;
    logic          dir;
    logic [NF-1:0] pend;
    logic          rej;
  } obs_t;

  typedef struct {
    obs_t  o;
    string name;
  } exp_t;

  logic          clk, reset, call_valid, call_up, call_cab, car_stopped, served;
  logic [FW-1:0] call_floor, actual_floor, target_floor;
  logic          target_valid, dir_up, call_reject;
  logic [1:0]    sched_state;
  logic [NF-1:0] pending;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic mon_on = 1'b0;
  logic have_prev = 1'b0;
  obs_t prev, cur;

  elevator_call_scheduler #(.N_FLOORS(NF), .FLOOR_W(FW)) dut (
    .clk(clk), .reset(reset), .call_valid(call_valid), .call_floor(call_floor),
    .call_up(call_up), .call_cab(call_cab), .actual_floor(actual_floor),
    .car_stopped(car_stopped), .served(served), .target_floor(target_floor),
    .target_valid(target_valid), .dir_up(dir_up), .sched_state(sched_state),
    .pending(pending), .call_reject(call_reject)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [1:0] st, input logic tv, input logic [FW-1:0] tgt,
                              input logic dir, input logic [NF-1:0] pend, input logic rej);
    obs_t o;
    o.st = st; o.tv = tv; o.tgt = tgt; o.dir = dir; o.pend = pend; o.rej = rej;
    return o;
  endfunction

  task automatic push_exp(input string name, input obs_t o);
    exp_t e;
    e.o = o;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic call(input logic [FW-1:0] f, input logic up, input logic cab);
    call_valid = 1'b1; call_floor = f; call_up = up; call_cab = cab;
    step(1);
    call_valid = 1'b0;
  endtask

  task automatic serve_pulse();
    served = 1'b1;
    step(1);
    served = 1'b0;
  endtask

  // Monitor: each change of the output tuple must match the next expectation.
  always @(negedge clk) begin
    if (mon_on) begin
      cur = mk(sched_state, target_valid, target_floor, dir_up, pending, call_reject);
      if (!have_prev || cur != prev) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got st=%0d tv=%0d tgt=%0d dir=%0d pend=%h rej=%0d, required no change",
                   cur.st, cur.tv, cur.tgt, cur.dir, cur.pend, cur.rej);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (cur !== e.o) begin
            n_fail++;
            $display("FAIL %s: got st=%0d tv=%0d tgt=%0d dir=%0d pend=%h rej=%0d, required st=%0d tv=%0d tgt=%0d dir=%0d pend=%h rej=%0d",
                     e.name, cur.st, cur.tv, cur.tgt, cur.dir, cur.pend, cur.rej,
                     e.o.st, e.o.tv, e.o.tgt, e.o.dir, e.o.pend, e.o.rej);
          end
        end
        prev = cur;
        have_prev = 1'b1;
      end
    end
  end

  initial begin
    reset = 1'b1; call_valid = 1'b0; call_floor = '0; call_up = 1'b0; call_cab = 1'b0;
    actual_floor = '0; car_stopped = 1'b1; served = 1'b0;
    step(3);
    reset = 1'b0;
    push_exp("reset_state", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0));
    mon_on = 1'b1;
    step(4);

    // Car parked at 2, cab call to 5.
    actual_floor = 4'd2;
    step(2);
    push_exp("cab5_capture", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h20, 1'b0));
    push_exp("cab5_target",  mk(2'd1, 1'b1, 4'd5, 1'b1, 8'h20, 1'b0));
    call(4'd5, 1'b0, 1'b1);
    step(3);
    push_exp("arrive5_serve", mk(2'd3, 1'b1, 4'd5, 1'b1, 8'h20, 1'b0));
    actual_floor = 4'd5;
    step(3);
    push_exp("served5_idle", mk(2'd0, 1'b0, 4'd5, 1'b1, 8'h00, 1'b0));
    serve_pulse();
    step(3);

    // Sweep: cab 6, hall-down 1, then hall-up 4 retargets.
    actual_floor = 4'd3;
    step(1);
    push_exp("cab6_capture", mk(2'd0, 1'b0, 4'd5, 1'b1, 8'h40, 1'b0));
    push_exp("up_target6",   mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h40, 1'b0));
    call(4'd6, 1'b0, 1'b1);
    step(3);
    car_stopped = 1'b0;
    push_exp("dn1_capture", mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h42, 1'b0));
    call(4'd1, 1'b0, 1'b0);
    step(3);
    push_exp("up4_capture", mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h52, 1'b0));
    push_exp("retarget4",   mk(2'd1, 1'b1, 4'd4, 1'b1, 8'h52, 1'b0));
    call(4'd4, 1'b1, 1'b0);
    step(3);
    push_exp("serve4", mk(2'd3, 1'b1, 4'd4, 1'b1, 8'h52, 1'b0));
    actual_floor = 4'd4; car_stopped = 1'b1;
    step(3);
    push_exp("resume_up6", mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h42, 1'b0));
    serve_pulse();
    step(3);
    push_exp("serve6", mk(2'd3, 1'b1, 4'd6, 1'b1, 8'h42, 1'b0));
    actual_floor = 4'd6;
    step(3);
    push_exp("reverse_down1", mk(2'd2, 1'b1, 4'd1, 1'b0, 8'h02, 1'b0));
    serve_pulse();
    step(3);
    push_exp("serve1", mk(2'd3, 1'b1, 4'd1, 1'b0, 8'h02, 1'b0));
    actual_floor = 4'd1;
    step(3);
    push_exp("idle_after1", mk(2'd0, 1'b0, 4'd1, 1'b0, 8'h00, 1'b0));
    serve_pulse();
    step(3);

    // Illegal position parks the scheduler while both tie calls load.
    actual_floor = 4'd15;
    step(2);
    push_exp("tie_cap2", mk(2'd0, 1'b0, 4'd1, 1'b0, 8'h04, 1'b0));
    call(4'd2, 1'b0, 1'b1);
    step(2);
    push_exp("tie_cap6", mk(2'd0, 1'b0, 4'd1, 1'b0, 8'h44, 1'b0));
    call(4'd6, 1'b0, 1'b1);
    step(2);
    push_exp("tie_goes_up6", mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h44, 1'b0));
    actual_floor = 4'd4;
    step(3);
    push_exp("up5_capture", mk(2'd1, 1'b1, 4'd6, 1'b1, 8'h64, 1'b0));
    push_exp("retarget5",   mk(2'd1, 1'b1, 4'd5, 1'b1, 8'h64, 1'b0));
    call(4'd5, 1'b1, 1'b0);
    step(3);
    push_exp("serve5_three_pending", mk(2'd3, 1'b1, 4'd5, 1'b1, 8'h64, 1'b0));
    actual_floor = 4'd5;
    step(3);
    push_exp("reset_in_serve", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(3);

    // Illegal calls: one reject pulse each, nothing registered.
    push_exp("rej_up_top",     mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b1));
    push_exp("rej_up_top_end", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0));
    call(4'd7, 1'b1, 1'b0);
    step(3);
    push_exp("rej_dn_bottom",     mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b1));
    push_exp("rej_dn_bottom_end", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0));
    call(4'd0, 1'b0, 1'b0);
    step(3);
    push_exp("rej_floor9",     mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b1));
    push_exp("rej_floor9_end", mk(2'd0, 1'b0, 4'd0, 1'b1, 8'h00, 1'b0));
    call(4'd9, 1'b0, 1'b1);
    step(5);

    mon_on = 1'b0;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no output change, required st=%0d tv=%0d tgt=%0d dir=%0d pend=%h rej=%0d",
               e.name, e.o.st, e.o.tv, e.o.tgt, e.o.dir, e.o.pend, e.o.rej);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
Parametrised successor to the fixed 3-bit call comparator. Registers hall calls (up/down) and cab calls for N_FLOORS floors. Selects the next target floor using a directional sweep (SCAN): keep serving in the current direction, then reverse. Sits between the call-button decoder and the motor/door controller FSM.

Parameters:
N_FLOORS, 8, number of floors served (floors 0..N_FLOORS-1), range 2..32
FLOOR_W, 3, floor index width; must satisfy 2**FLOOR_W >= N_FLOORS

Ports:
clk  in  1  system clock; single clock domain
reset  in  1  synchronous, active-high reset
call_valid  in  1  one-cycle strobe; a new call is present on call_floor/call_up/call_cab
call_floor  in  FLOOR_W  floor of the new call
call_up  in  1  hall-call direction: 1=up, 0=down; ignored when call_cab=1
call_cab  in  1  1=cab (in-car) call, 0=hall call
actual_floor  in  FLOOR_W  current car floor, from the position tracker
car_stopped  in  1  car is at rest, level with actual_floor
served  in  1  one-cycle strobe; doors have completed a stop at actual_floor
target_floor  out  FLOOR_W  registered next destination
target_valid  out  1  target_floor is meaningful
dir_up  out  1  sweep direction: 1=up, 0=down
sched_state  out  2  IDLE=0, UP=1, DOWN=2, SERVE=3
pending  out  N_FLOORS  per-floor OR of up_req, dn_req and cab_req
call_reject  out  1  one-cycle pulse when an illegal call is dropped

Behaviour:
- State: three request vectors (up_req, dn_req, cab_req, N_FLOORS bits each), a 2-bit FSM, dir_up and the output registers.
- Reset: all request bits 0, sched_state=IDLE, target_floor=0, target_valid=0, dir_up=1, call_reject=0. Reset during any state drops all pending calls immediately.
- Call capture: a call with call_valid=1 in cycle t sets its request bit at t+1. Repeat calls are idempotent.
- Illegal calls, each giving call_reject=1 at t+1 with no bit set:
  - call_floor >= N_FLOORS
  - hall up at floor N_FLOORS-1
  - hall down at floor 0
- Service clear, when served=1 at floor F:
  - clear cab_req[F] and the hall bit for the current dir_up.
  - also clear the opposite hall bit if no request exists beyond F in dir_up.
- Simultaneous call and clear of the same bit: clear wins; the call is lost and no reject is raised.
- Target timing: target_floor/target_valid are registered from the request vectors. A call at t gives a target update at t+2.
- IDLE:
  - pending==0: target_valid=0.
  - Request at actual_floor and car_stopped: go to SERVE, target=actual_floor.
  - Otherwise go to the nearest requested floor; equal distance goes up. Set dir_up accordingly, then go to UP or DOWN.
- UP:
  - Target = lowest floor above actual_floor with up_req|cab_req.
  - If none, target = highest floor above with dn_req.
  - If nothing is above, go to DOWN when requests exist below, else IDLE.
  - car_stopped with actual_floor==target_floor: go to SERVE.
  - A newly registered nearer call above actual_floor retargets on the next cycle.
- DOWN: mirror of UP (highest floor below with dn_req|cab_req, then lowest floor below with up_req).
- SERVE:
  - Hold target until served=1, then clear bits.
  - Next state: same direction if requests remain that way, else reverse, else IDLE.
  - Calls arriving during SERVE are captured normally.
- Boundaries:
  - Wrap-around never occurs; searches are bounded to 0..N_FLOORS-1.
  - served outside SERVE is ignored.
  - actual_floor >= N_FLOORS forces IDLE with target_valid=0 until the floor is legal.

Decomposition:
- Shared package elevator_pkg holds the sched_state encodings (IDLE/UP/DOWN/SERVE) and the hall-direction constants.
- One sub-module, floor_seek (purely combinational, parametrised by N_FLOORS), returns found flag plus index for two searches:
  - lowest set bit strictly above a given floor
  - highest set bit strictly below a given floor
- The scheduler instantiates floor_seek four times.

Test Plan:
- Reset then idle: no calls -> sched_state=IDLE, target_valid=0, pending=0.
- N_FLOORS=8, car at floor 2 stopped, cab call floor 5 at t -> target_floor=5, dir_up=1, sched_state=UP at t+2. Then car_stopped at 5 -> SERVE; served -> pending=0, IDLE.
- Car at 3 moving up, pending cab 6 and hall-down 1; then hall-up 4 arrives -> target 4, then 6, then reverse to DOWN with target 1.
- Car at 4, calls at floors 2 and 6 (tie) -> dir_up=1, target 6.
- Illegal calls: hall up at floor 7, hall down at floor 0, floor 9 -> call_reject pulse each, pending unchanged.
- Reset asserted in SERVE with 3 pending calls -> next cycle all outputs at reset values, pending=0.
